// File: rtl/peri_bus_arbiter_if.sv
// rtl/peri_bus_arbiter_if.sv - master-side and peripheral-side bus bundle for peri_bus_arbiter
interface peri_bus_arbiter_if #(
    parameter int NumMasters = 2
);
    logic [NumMasters-1:0]      m_req;
    logic [32*NumMasters-1:0]   m_addr;
    logic [NumMasters-1:0]      m_write;
    logic [4*NumMasters-1:0]    m_be;
    logic [32*NumMasters-1:0]   m_wdata;
    logic [NumMasters-1:0]      m_gnt;
    logic [NumMasters-1:0]      m_rvalid;
    logic [31:0]                m_rdata;

    logic                       peri_req;
    logic [31:0]                peri_addr;
    logic                       peri_write;
    logic [3:0]                 peri_be;
    logic [31:0]                peri_wdata;
    logic                       peri_gnt;
    logic                       peri_rvalid;
    logic [31:0]                peri_rdata;

    modport slave (
        input  m_req, m_addr, m_write, m_be, m_wdata,
        output m_gnt, m_rvalid, m_rdata,
        output peri_req, peri_addr, peri_write, peri_be, peri_wdata,
        input  peri_gnt, peri_rvalid, peri_rdata
    );

    modport master (
        output m_req, m_addr, m_write, m_be, m_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        input  peri_req, peri_addr, peri_write, peri_be, peri_wdata,
        output peri_gnt, peri_rvalid, peri_rdata
    );
endinterface

// File: rtl/peri_bus_arbiter.sv
// rtl/peri_bus_arbiter.sv - round-robin peripheral port arbiter with grant lock and in-order response routing
module peri_bus_arbiter #(
    parameter int NumMasters     = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                clk,
    input  logic                rst,
    peri_bus_arbiter_if.slave   bus,
    output logic                err_unexp_rvalid
);
    localparam int IdW  = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding) + 1;
    localparam logic [NumMasters-1:0] OneHot0 = NumMasters'(1);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_t;

    state_t             state;
    logic [IdW-1:0]     rr_ptr;
    logic [IdW-1:0]     lock_id;
    logic [IdW-1:0]     id_fifo [MaxOutstanding];
    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW-1:0]    rd_ptr;
    logic [CntW-1:0]    count;

    logic               slot_ok;
    logic               found;
    logic [IdW-1:0]     sel;
    logic               fwd_valid;
    logic [IdW-1:0]     fwd_id;
    logic               push;
    logic               pop;

    function automatic logic [PtrW-1:0] fifo_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IdW-1:0] master_inc(input logic [IdW-1:0] id);
        return (id == IdW'(NumMasters - 1)) ? '0 : id + 1'b1;
    endfunction

    assign slot_ok = (count < CntW'(MaxOutstanding));

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NumMasters; k++) begin
            if (!found && bus.m_req[(int'(rr_ptr) + k) % NumMasters]) begin
                found = 1'b1;
                sel   = IdW'((int'(rr_ptr) + k) % NumMasters);
            end
        end
    end

    // While locked only the stalled master is forwarded, and it loses the lock if it withdraws.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_id    = '0;
        if (state == WAIT_GNT) begin
            fwd_valid = slot_ok && bus.m_req[lock_id];
            fwd_id    = lock_id;
        end else begin
            fwd_valid = slot_ok && found;
            fwd_id    = sel;
        end
    end

    assign push = fwd_valid && bus.peri_gnt;
    assign pop  = bus.peri_rvalid && (count != '0);

    always_comb begin
        bus.peri_req   = fwd_valid;
        bus.peri_addr  = '0;
        bus.peri_write = 1'b0;
        bus.peri_be    = '0;
        bus.peri_wdata = '0;
        if (fwd_valid) begin
            bus.peri_addr  = bus.m_addr[int'(fwd_id)*32 +: 32];
            bus.peri_write = bus.m_write[fwd_id];
            bus.peri_be    = bus.m_be[int'(fwd_id)*4 +: 4];
            bus.peri_wdata = bus.m_wdata[int'(fwd_id)*32 +: 32];
        end
    end

    assign bus.m_gnt    = push ? (OneHot0 << fwd_id) : '0;
    assign bus.m_rvalid = pop ? (OneHot0 << id_fifo[rd_ptr]) : '0;
    assign bus.m_rdata  = bus.peri_rvalid ? bus.peri_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            lock_id          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            err_unexp_rvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fwd_valid) begin
                        if (bus.peri_gnt) begin
                            rr_ptr <= master_inc(sel);
                        end else begin
                            lock_id <= sel;
                            state   <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (!bus.m_req[lock_id]) begin
                        state <= IDLE;
                    end else if (push) begin
                        rr_ptr <= master_inc(lock_id);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                id_fifo[wr_ptr] <= fwd_id;
                wr_ptr          <= fifo_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= fifo_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase

            if (bus.peri_rvalid && (count == '0)) begin
                err_unexp_rvalid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_peri_bus_arbiter.sv
// tb/tb_peri_bus_arbiter.sv - self-checking bench for peri_bus_arbiter against a queue-based reference model
module tb_peri_bus_arbiter;
    localparam int NM   = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_unexp_rvalid;

    peri_bus_arbiter_if #(.NumMasters(NM)) bus ();

    peri_bus_arbiter #(.NumMasters(NM), .MaxOutstanding(MAXO)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .err_unexp_rvalid (err_unexp_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int q[$];
    int rr;
    int lock;
    bit merr;

    logic        exp_req;
    int          exp_id;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_write;
    logic [31:0] exp_rdata;

    function automatic void model_eval();
        exp_req = 1'b0;
        exp_id  = 0;
        if (q.size() < MAXO) begin
            if (lock >= 0) begin
                exp_req = bus.m_req[lock];
                exp_id  = lock;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    int c;
                    c = (rr + k) % NM;
                    if (!exp_req && bus.m_req[c]) begin
                        exp_req = 1'b1;
                        exp_id  = c;
                    end
                end
            end
        end
        exp_addr  = exp_req ? bus.m_addr[exp_id*32 +: 32] : 32'h0;
        exp_wdata = exp_req ? bus.m_wdata[exp_id*32 +: 32] : 32'h0;
        exp_be    = exp_req ? bus.m_be[exp_id*4 +: 4] : 4'h0;
        exp_write = exp_req ? bus.m_write[exp_id] : 1'b0;
        exp_gnt   = (exp_req && bus.peri_gnt) ? (2'b01 << exp_id) : 2'b00;
        exp_rv    = (bus.peri_rvalid && q.size() > 0) ? (2'b01 << q[0]) : 2'b00;
        exp_rdata = bus.peri_rvalid ? bus.peri_rdata : 32'h0;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            q.delete();
            rr   = 0;
            lock = -1;
            merr = 1'b0;
        end else begin
            if (bus.peri_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1'b1;
            end
            if (exp_gnt != 2'b00) begin
                q.push_back(exp_id);
                rr   = (exp_id + 1) % NM;
                lock = -1;
            end else if (exp_req) begin
                lock = exp_id;
            end else begin
                lock = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.m_req       = '0;
        bus.m_addr      = '0;
        bus.m_write     = '0;
        bus.m_be        = '0;
        bus.m_wdata     = '0;
        bus.peri_gnt    = 1'b0;
        bus.peri_rvalid = 1'b0;
        bus.peri_rdata  = '0;
    endtask

    task automatic set_master(input int i, input logic req, input logic [31:0] addr,
                              input logic wr, input logic [3:0] be, input logic [31:0] wd);
        bus.m_req[i]           = req;
        bus.m_addr[i*32 +: 32] = addr;
        bus.m_write[i]         = wr;
        bus.m_be[i*4 +: 4]     = be;
        bus.m_wdata[i*32 +: 32] = wd;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.m_req    = '0;
        bus.peri_gnt = 1'b0;
        while (q.size() > 0 && guard < 16) begin
            bus.peri_rvalid = 1'b1;
            bus.peri_rdata  = $urandom;
            #1;
            model_eval();
            checks++;
            if (bus.m_rvalid !== exp_rv) begin
                errors++;
                $display("FAIL drain_route: got %b expected %b", bus.m_rvalid, exp_rv);
            end
            tick();
            guard++;
        end
        bus.peri_rvalid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_bound: %0d entries left, expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.peri_req, bus.m_gnt, bus.m_rvalid, err_unexp_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b gnt=%b rv=%b err=%b expected all 0",
                     bus.peri_req, bus.m_gnt, bus.m_rvalid, err_unexp_rvalid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dut.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", dut.count);
        end
    endtask

    task automatic test_single();
        logic [31:0] wd, rd;
        wd = $urandom;
        rd = $urandom;
        clear_inputs();
        set_master(0, 1'b1, 32'h10, 1'b1, 4'hf, wd);
        bus.peri_gnt = 1'b1;
        #1;
        checks++;
        if (bus.m_gnt !== 2'b01) begin
            errors++;
            $display("FAIL single_gnt: got %b expected 01", bus.m_gnt);
        end
        checks++;
        if ({bus.peri_req, bus.peri_addr, bus.peri_write, bus.peri_wdata} !== {1'b1, 32'h10, 1'b1, wd}) begin
            errors++;
            $display("FAIL single_fwd: got addr=%h wr=%b wd=%h expected addr=10 wr=1 wd=%h",
                     bus.peri_addr, bus.peri_write, bus.peri_wdata, wd);
        end
        tick();
        clear_inputs();
        bus.peri_rvalid = 1'b1;
        bus.peri_rdata  = rd;
        #1;
        checks++;
        if (bus.m_rvalid !== 2'b01 || bus.m_rdata !== rd) begin
            errors++;
            $display("FAIL single_resp: got rv=%b data=%h expected rv=01 data=%h", bus.m_rvalid, bus.m_rdata, rd);
        end
        tick();
        bus.peri_rvalid = 1'b0;
        #1;
        checks++;
        if (dut.count !== 3'd0) begin
            errors++;
            $display("FAIL single_count: got %0d expected 0", dut.count);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] last;
        last = 2'b00;
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            set_master(0, 1'b1, $urandom, 1'b0, 4'hf, $urandom);
            set_master(1, 1'b1, $urandom, 1'b1, 4'h3, $urandom);
            bus.peri_gnt    = 1'b1;
            bus.peri_rvalid = (i > 0);
            bus.peri_rdata  = $urandom;
            #1;
            model_eval();
            checks++;
            if (bus.m_gnt !== exp_gnt || bus.m_gnt === last || bus.m_gnt === 2'b00) begin
                errors++;
                $display("FAIL alt_gnt[%0d]: got %b expected %b (previous %b)", i, bus.m_gnt, exp_gnt, last);
            end
            checks++;
            if (bus.m_rvalid !== exp_rv || bus.m_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL alt_resp[%0d]: got rv=%b data=%h expected rv=%b data=%h",
                         i, bus.m_rvalid, bus.m_rdata, exp_rv, exp_rdata);
            end
            last = bus.m_gnt;
            tick();
        end
        drain();
    endtask

    task automatic test_lock();
        logic [31:0] a0, a1;
        a0 = $urandom;
        a1 = $urandom;
        clear_inputs();
        set_master(0, 1'b0, a0, 1'b0, 4'h1, 32'h0);
        set_master(1, 1'b1, a1, 1'b1, 4'h2, 32'h5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) bus.m_req[0] = 1'b1;
            #1;
            checks++;
            if (bus.peri_addr !== a1 || bus.peri_req !== 1'b1 || bus.m_gnt !== 2'b00) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got addr=%h req=%b gnt=%b expected addr=%h req=1 gnt=00",
                         i, bus.peri_addr, bus.peri_req, bus.m_gnt, a1);
            end
            tick();
        end
        bus.peri_gnt = 1'b1;
        #1;
        checks++;
        if (bus.m_gnt !== 2'b10) begin
            errors++;
            $display("FAIL lock_gnt: got %b expected 10", bus.m_gnt);
        end
        tick();
        #1;
        checks++;
        if (bus.m_gnt !== 2'b01 || bus.peri_addr !== a0) begin
            errors++;
            $display("FAIL lock_next: got gnt=%b addr=%h expected gnt=01 addr=%h", bus.m_gnt, bus.peri_addr, a0);
        end
        tick();
        drain();
    endtask

    task automatic test_full();
        clear_inputs();
        set_master(0, 1'b1, 32'h100, 1'b0, 4'hf, 32'h0);
        bus.peri_gnt = 1'b1;
        for (int i = 0; i < MAXO; i++) begin
            #1;
            checks++;
            if (bus.m_gnt !== 2'b01) begin
                errors++;
                $display("FAIL full_fill[%0d]: got %b expected 01", i, bus.m_gnt);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.peri_req !== 1'b0 || bus.m_gnt !== 2'b00) begin
            errors++;
            $display("FAIL full_block: got req=%b gnt=%b expected req=0 gnt=00", bus.peri_req, bus.m_gnt);
        end
        tick();
        bus.peri_rvalid = 1'b1;
        bus.peri_rdata  = $urandom;
        #1;
        checks++;
        if (bus.m_gnt !== 2'b00 || bus.m_rvalid !== 2'b01) begin
            errors++;
            $display("FAIL full_release: got gnt=%b rv=%b expected gnt=00 rv=01", bus.m_gnt, bus.m_rvalid);
        end
        tick();
        bus.peri_rvalid = 1'b0;
        #1;
        checks++;
        if (bus.m_gnt !== 2'b01) begin
            errors++;
            $display("FAIL full_resume: got %b expected 01", bus.m_gnt);
        end
        tick();
        drain();
    endtask

    task automatic test_same_cycle();
        clear_inputs();
        bus.m_req    = 2'b11;
        bus.peri_gnt = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        checks++;
        if (dut.count !== 3'd3) begin
            errors++;
            $display("FAIL same_fill: got count %0d expected 3", dut.count);
        end
        bus.peri_rvalid = 1'b1;
        bus.peri_rdata  = $urandom;
        #1;
        model_eval();
        checks++;
        if (bus.m_rvalid !== exp_rv || bus.m_gnt !== exp_gnt || exp_gnt == 2'b00) begin
            errors++;
            $display("FAIL same_route: got rv=%b gnt=%b expected rv=%b gnt=%b", bus.m_rvalid, bus.m_gnt, exp_rv, exp_gnt);
        end
        tick();
        bus.peri_rvalid = 1'b0;
        bus.peri_gnt    = 1'b0;
        bus.m_req       = 2'b00;
        #1;
        checks++;
        if (dut.count !== 3'd3) begin
            errors++;
            $display("FAIL same_count: got %0d expected 3", dut.count);
        end
        drain();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < NM; m++) begin
                set_master(m, 1'($urandom), $urandom, 1'($urandom), 4'($urandom), $urandom);
            end
            bus.peri_gnt    = 1'($urandom);
            bus.peri_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.peri_rdata  = $urandom;
            #1;
            model_eval();
            checks++;
            if ({bus.peri_req, bus.peri_addr, bus.peri_write, bus.peri_be, bus.peri_wdata} !==
                {exp_req, exp_addr, exp_write, exp_be, exp_wdata}) begin
                errors++;
                $display("FAIL rand_fwd[%0d]: got req=%b addr=%h wr=%b be=%h wd=%h expected req=%b addr=%h wr=%b be=%h wd=%h",
                         i, bus.peri_req, bus.peri_addr, bus.peri_write, bus.peri_be, bus.peri_wdata,
                         exp_req, exp_addr, exp_write, exp_be, exp_wdata);
            end
            checks++;
            if (bus.m_gnt !== exp_gnt || bus.m_rvalid !== exp_rv || bus.m_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_gnt_resp[%0d]: got gnt=%b rv=%b data=%h expected gnt=%b rv=%b data=%h",
                         i, bus.m_gnt, bus.m_rvalid, bus.m_rdata, exp_gnt, exp_rv, exp_rdata);
            end
            checks++;
            if (err_unexp_rvalid !== merr) begin
                errors++;
                $display("FAIL rand_err[%0d]: got %b expected %b", i, err_unexp_rvalid, merr);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_err();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.peri_rvalid = 1'b1;
        bus.peri_rdata  = $urandom;
        #1;
        checks++;
        if (bus.m_rvalid !== 2'b00 || err_unexp_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL err_drop: got rv=%b err=%b expected rv=00 err=0", bus.m_rvalid, err_unexp_rvalid);
        end
        tick();
        bus.peri_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (err_unexp_rvalid !== 1'b1 || merr != 1'b1) begin
                errors++;
                $display("FAIL err_sticky[%0d]: got %b expected 1", i, err_unexp_rvalid);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (err_unexp_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err_unexp_rvalid);
        end
    endtask

    initial begin
        rst  = 1'b1;
        rr   = 0;
        lock = -1;
        merr = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_same_cycle();
        test_random();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
